// File: rtl/prog_encoder_pkg.sv
// Shared types, constants and the instruction packing function for the
// program encoder/loader.
package prog_pkg;

  typedef enum logic [1:0] {
    KIND_DP  = 2'd0,
    KIND_LDR = 2'd1,
    KIND_STR = 2'd2,
    KIND_B   = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0]  COND_AL   = 4'hE;
  // Unconditional branch with offset -2: jumps to itself (PC+8-8).
  localparam logic [31:0] HALT_WORD = 32'hEAFF_FFFE;

  // Instruction field positions
  localparam int unsigned COND_LSB  = 28;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned I_BIT     = 25;
  localparam int unsigned CMD_LSB   = 21;
  localparam int unsigned S_BIT     = 20;
  localparam int unsigned P_BIT     = 24;
  localparam int unsigned U_BIT     = 23;
  localparam int unsigned B_BIT     = 22;
  localparam int unsigned W_BIT     = 21;
  localparam int unsigned L_BIT     = 20;
  localparam int unsigned BF_LSB    = 24;
  localparam int unsigned RN_LSB    = 16;
  localparam int unsigned RD_LSB    = 12;
  localparam int unsigned SRC2_LSB  = 0;
  localparam int unsigned OFF_LSB   = 0;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Pack one request into a 32-bit instruction word; fields not used by
  // the given kind are ignored.
  function automatic logic [31:0] encode_instr(
    input kind_t       kind,
    input logic [3:0]  cond,
    input logic        imm,
    input logic [3:0]  cmd,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] src2,
    input logic [23:0] off
  );
    logic [31:0] w;
    w = '0;
    w[COND_LSB +: 4] = cond;
    case (kind)
      KIND_DP: begin
        w[OP_LSB +: 2]   = OP_DP;
        w[I_BIT]         = imm;
        w[CMD_LSB +: 4]  = cmd;
        w[S_BIT]         = 1'b0;
        w[RN_LSB +: 4]   = rn;
        w[RD_LSB +: 4]   = rd;
        w[SRC2_LSB +: 12] = src2;
      end
      KIND_LDR, KIND_STR: begin
        // Memory ops use an inverted immediate flag (I=0 means immediate offset).
        w[OP_LSB +: 2]   = OP_MEM;
        w[I_BIT]         = ~imm;
        w[P_BIT]         = 1'b1;
        w[U_BIT]         = 1'b1;
        w[B_BIT]         = 1'b0;
        w[W_BIT]         = 1'b0;
        w[L_BIT]         = (kind == KIND_LDR);
        w[RN_LSB +: 4]   = rn;
        w[RD_LSB +: 4]   = rd;
        w[SRC2_LSB +: 12] = src2;
      end
      KIND_B: begin
        w[OP_LSB +: 2]   = OP_BR;
        w[BF_LSB +: 2]   = 2'b10;
        w[OFF_LSB +: 24] = off;
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/prog_encoder_fifo.sv
// Synchronous FIFO buffering encoded words between request and imem sides.
module enc_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign head    = mem_q[rptr_q[PW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointers and storage contents
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (do_push) begin
      mem_d[wptr_q[PW-1:0]] = din;
      wptr_d = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  // State registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/prog_encoder.sv
// Program encoder/loader: encodes instruction requests, buffers them and
// writes them to consecutive imem words, finishing with a halt word.
module prog_encoder
  import prog_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMEM_AW    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_kind,
  input  logic [3:0]         req_cond,
  input  logic               req_imm,
  input  logic [3:0]         req_cmd,
  input  logic [3:0]         req_rn,
  input  logic [3:0]         req_rd,
  input  logic [11:0]        req_src2,
  input  logic [23:0]        req_off,
  input  logic               finish,
  output logic               imem_we,
  input  logic               imem_ready,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [IMEM_AW:0]   word_count,
  output logic               done,
  output logic               overflow
);

  localparam logic [IMEM_AW:0] CNT_ONE = 1;

  state_t             state_q, state_d;
  logic [IMEM_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic [31:0]        fifo_head;
  logic [31:0]        enc_word;
  logic               push;
  logic               pop;
  logic               mem_full;

  assign enc_word = encode_instr(kind_t'(req_kind), req_cond, req_imm, req_cmd,
                                 req_rn, req_rd, req_src2, req_off);

  // Count saturates at 2**IMEM_AW, so the top bit alone flags a full imem.
  assign mem_full = count_q[IMEM_AW];

  enc_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (enc_word),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Handshake, imem write path and FSM next state
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    imem_we    = 1'b0;
    imem_wdata = '0;

    // Gating with rst_n keeps every output quiet while reset is held.
    req_ready = rst_n && (state_q == ST_RUN) && !fifo_full;
    push      = req_valid && req_ready;

    if (rst_n) begin
      case (state_q)
        ST_RUN, ST_DRAIN: begin
          if (!fifo_empty) begin
            if (mem_full) begin
              pop        = 1'b1;
              overflow_d = 1'b1;
            end else begin
              imem_we    = 1'b1;
              imem_wdata = fifo_head;
              if (imem_ready) begin
                pop     = 1'b1;
                count_d = count_q + CNT_ONE;
              end
            end
          end
          if (state_q == ST_RUN) begin
            if (finish) state_d = ST_DRAIN;
          end else if (fifo_empty) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          if (mem_full) begin
            overflow_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            imem_we    = 1'b1;
            imem_wdata = HALT_WORD;
            if (imem_ready) begin
              count_d = count_q + CNT_ONE;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State, address counter and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign imem_addr  = count_q[IMEM_AW-1:0];
  assign word_count = count_q;
  assign done       = (state_q == ST_DONE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_prog_encoder.sv
// Directed self-checking bench for prog_encoder (default size and IMEM_AW=2).
module tb_prog_encoder;

  logic        clk;
  logic        rst_n;
  logic        req_valid, s_req_valid;
  logic        req_ready, s_req_ready;
  logic [1:0]  req_kind;
  logic [3:0]  req_cond;
  logic        req_imm;
  logic [3:0]  req_cmd;
  logic [3:0]  req_rn;
  logic [3:0]  req_rd;
  logic [11:0] req_src2;
  logic [23:0] req_off;
  logic        finish, s_finish;
  logic        imem_we, s_imem_we;
  logic        imem_ready;
  logic [5:0]  imem_addr;
  logic [1:0]  s_imem_addr;
  logic [31:0] imem_wdata, s_imem_wdata;
  logic [6:0]  word_count;
  logic [2:0]  s_word_count;
  logic        done, s_done;
  logic        overflow, s_overflow;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [31:0] log_mem [64];
  logic [31:0] s_log [4];
  int unsigned wr_cnt;
  int unsigned s_wr_cnt;

  prog_encoder #(.FIFO_DEPTH(4), .IMEM_AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_cond(req_cond), .req_imm(req_imm), .req_cmd(req_cmd),
    .req_rn(req_rn), .req_rd(req_rd), .req_src2(req_src2), .req_off(req_off),
    .finish(finish), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
    .done(done), .overflow(overflow)
  );

  prog_encoder #(.FIFO_DEPTH(4), .IMEM_AW(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_kind(req_kind), .req_cond(req_cond), .req_imm(req_imm), .req_cmd(req_cmd),
    .req_rn(req_rn), .req_rd(req_rd), .req_src2(req_src2), .req_off(req_off),
    .finish(s_finish), .imem_we(s_imem_we), .imem_ready(imem_ready),
    .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .word_count(s_word_count),
    .done(s_done), .overflow(s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted imem write of each instance
  always @(posedge clk) begin
    if (!rst_n) wr_cnt <= 0;
    else if (imem_we && imem_ready) begin
      log_mem[imem_addr] <= imem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) s_wr_cnt <= 0;
    else if (s_imem_we && imem_ready) begin
      s_log[s_imem_addr] <= s_imem_wdata;
      s_wr_cnt <= s_wr_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; s_req_valid = 1'b0;
    finish = 1'b0; s_finish = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input bit sel, input logic [1:0] kind, input logic [3:0] cond,
                      input logic imm, input logic [3:0] cmd, input logic [3:0] rn,
                      input logic [3:0] rd, input logic [11:0] src2, input logic [23:0] off);
    logic rdy;
    req_kind = kind; req_cond = cond; req_imm = imm; req_cmd = cmd;
    req_rn = rn; req_rd = rd; req_src2 = src2; req_off = off;
    if (sel) s_req_valid = 1'b1; else req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rdy = sel ? s_req_ready : req_ready;
      if (rdy) break;
      tick();
    end
    rdy = sel ? s_req_ready : req_ready;
    chk("send_ready", {31'd0, rdy}, 32'd1);
    tick();
    req_valid = 1'b0;
    s_req_valid = 1'b0;
  endtask

  // DP ADD R1,R2,#src2 with cond AL
  task automatic dp(input bit sel, input logic [11:0] src2);
    send(sel, 2'd0, 4'hE, 1'b1, 4'd4, 4'd2, 4'd1, src2, 24'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1;
    req_valid = 1'b0; s_req_valid = 1'b0; finish = 1'b0; s_finish = 1'b0;
    req_kind = '0; req_cond = '0; req_imm = 1'b0; req_cmd = '0;
    req_rn = '0; req_rd = '0; req_src2 = '0; req_off = '0;
    tick();
    tick();

    // Reset state while rst_n still low
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_count", {25'd0, word_count}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_s_ovf", {31'd0, s_overflow}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("run_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: DP ADD R1,R2,#5, write visible the cycle after acceptance
    dp(1'b0, 12'd5);
    chk("t1_we", {31'd0, imem_we}, 32'd1);
    chk("t1_addr", {26'd0, imem_addr}, 32'd0);
    chk("t1_wdata", imem_wdata, 32'hE282_1005);
    tick();
    chk("t1_log0", log_mem[0], 32'hE282_1005);
    chk("t1_count", {25'd0, word_count}, 32'd1);

    // 2: LDR, STR, B
    do_reset();
    send(1'b0, 2'd1, 4'hE, 1'b1, 4'd0, 4'd4, 4'd3, 12'd8, 24'd0);
    send(1'b0, 2'd2, 4'hE, 1'b1, 4'd0, 4'd4, 4'd3, 12'd8, 24'd0);
    send(1'b0, 2'd3, 4'hE, 1'b0, 4'd0, 4'd0, 4'd0, 12'd0, 24'd3);
    tick(); tick(); tick();
    chk("t2_ldr", log_mem[0], 32'hE594_3008);
    chk("t2_str", log_mem[1], 32'hE584_3008);
    chk("t2_b", log_mem[2], 32'hEA00_0003);
    chk("t2_count", {25'd0, word_count}, 32'd3);

    // 3: backpressure fills the FIFO, order preserved after release
    do_reset();
    imem_ready = 1'b0;
    dp(1'b0, 12'd1);
    dp(1'b0, 12'd2);
    dp(1'b0, 12'd3);
    dp(1'b0, 12'd4);
    req_valid = 1'b1; req_src2 = 12'd5;
    tick(); tick();
    chk("t3_full_ready", {31'd0, req_ready}, 32'd0);
    chk("t3_hold_we", {31'd0, imem_we}, 32'd1);
    chk("t3_hold_data", imem_wdata, 32'hE282_1001);
    chk("t3_hold_addr", {26'd0, imem_addr}, 32'd0);
    req_valid = 1'b0;
    imem_ready = 1'b1;
    dp(1'b0, 12'd5);
    for (int i = 0; i < 6; i++) tick();
    chk("t3_w0", log_mem[0], 32'hE282_1001);
    chk("t3_w1", log_mem[1], 32'hE282_1002);
    chk("t3_w2", log_mem[2], 32'hE282_1003);
    chk("t3_w3", log_mem[3], 32'hE282_1004);
    chk("t3_w4", log_mem[4], 32'hE282_1005);
    chk("t3_count", {25'd0, word_count}, 32'd5);
    chk("t3_wr_cnt", wr_cnt, 32'd5);

    // 4: finish after two words appends the halt word
    do_reset();
    dp(1'b0, 12'd1);
    dp(1'b0, 12'd2);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("t4_drain_ready", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (imem_we && imem_wdata == 32'hEAFF_FFFE) break;
      tick();
    end
    chk("t4_halt_seen", {31'd0, imem_we}, 32'd1);
    chk("t4_halt_addr", {26'd0, imem_addr}, 32'd2);
    chk("t4_done_before", {31'd0, done}, 32'd0);
    tick();
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_log2", log_mem[2], 32'hEAFF_FFFE);
    chk("t4_count", {25'd0, word_count}, 32'd3);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick(); tick();
    chk("t4_done_sticky", {31'd0, done}, 32'd1);
    chk("t4_no_write", {31'd0, imem_we}, 32'd0);
    chk("t4_count_hold", {25'd0, word_count}, 32'd3);
    chk("t4_wr_cnt", wr_cnt, 32'd3);

    // 5: IMEM_AW=2 overflows
    do_reset();
    dp(1'b1, 12'd1);
    dp(1'b1, 12'd2);
    dp(1'b1, 12'd3);
    dp(1'b1, 12'd4);
    dp(1'b1, 12'd5);
    tick(); tick(); tick();
    chk("t5_ovf_early", {31'd0, s_overflow}, 32'd1);
    chk("t5_not_done", {31'd0, s_done}, 32'd0);
    s_finish = 1'b1;
    tick();
    s_finish = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_done) break;
      tick();
    end
    chk("t5_done", {31'd0, s_done}, 32'd1);
    chk("t5_ovf", {31'd0, s_overflow}, 32'd1);
    chk("t5_count", {29'd0, s_word_count}, 32'd4);
    chk("t5_wr_cnt", s_wr_cnt, 32'd4);
    chk("t5_last", s_log[3], 32'hE282_1004);
    chk("t5_big_untouched", {31'd0, overflow}, 32'd0);

    // 6: reset mid-drain discards buffered words
    do_reset();
    imem_ready = 1'b0;
    dp(1'b0, 12'd1);
    dp(1'b0, 12'd2);
    dp(1'b0, 12'd3);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("t6_drain_ready", {31'd0, req_ready}, 32'd0);
    chk("t6_drain_we", {31'd0, imem_we}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("t6_rst_we", {31'd0, imem_we}, 32'd0);
    chk("t6_rst_wdata", imem_wdata, 32'h0);
    chk("t6_rst_addr", {26'd0, imem_addr}, 32'd0);
    chk("t6_rst_count", {25'd0, word_count}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    chk("t6_rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    tick();
    chk("t6_no_partial", wr_cnt, 32'd0);
    dp(1'b0, 12'd7);
    tick();
    chk("t6_log0", log_mem[0], 32'hE282_1007);
    chk("t6_count", {25'd0, word_count}, 32'd1);
    chk("t6_wr_cnt", wr_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
